// File: rtl/stacker_level_ctrl.sv
// Game-progression controller for the block stacker: level, live row width,
// level-dependent row-move tick and the IDLE/PLAY/WIN/LOSE state machine.
module stacker_level_ctrl #(
    parameter int NUM_LEVELS   = 15,
    parameter int LVL_W        = 4,
    parameter int START_BLOCKS = 3,
    parameter int BLK_W        = 2,
    parameter int SHRINK1      = 5,
    parameter int SHRINK2      = 10,
    parameter int PERIOD_W     = 24,
    parameter int BASE_PERIOD  = 5000000,
    parameter int PERIOD_STEP  = 300000,
    parameter int MIN_PERIOD   = 500000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             place_valid,
    input  logic [BLK_W-1:0] place_keep,
    output logic [LVL_W-1:0] level,
    output logic [BLK_W-1:0] num_blocks,
    output logic             move_tick,
    output logic [1:0]       game_state,
    output logic             win,
    output logic             game_over
);

    localparam int CW = PERIOD_W + LVL_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    // Floor is applied by comparing against the headroom, so the subtraction never wraps.
    function automatic logic [PERIOD_W-1:0] period_of(input logic [LVL_W-1:0] lvl);
        logic [CW-1:0] dec;
        logic [CW-1:0] span;
        if (lvl == LVL_W'(0)) begin
            dec = CW'(0);
        end else begin
            dec = CW'(lvl - LVL_W'(1)) * CW'(PERIOD_STEP);
        end
        span = CW'(BASE_PERIOD - MIN_PERIOD);
        if (dec >= span) begin
            return PERIOD_W'(MIN_PERIOD);
        end else begin
            return PERIOD_W'(CW'(BASE_PERIOD) - dec);
        end
    endfunction

    function automatic logic [BLK_W-1:0] cap_of(input logic [LVL_W-1:0] lvl);
        int sub;
        sub = 0;
        if (int'(lvl) >= SHRINK1) begin
            sub = sub + 1;
        end else begin
            sub = sub;
        end
        if (int'(lvl) >= SHRINK2) begin
            sub = sub + 1;
        end else begin
            sub = sub;
        end
        if (START_BLOCKS - sub >= 1) begin
            return BLK_W'(START_BLOCKS - sub);
        end else begin
            return BLK_W'(1);
        end
    endfunction

    state_t              state_r, state_n;
    logic [LVL_W-1:0]    level_r, level_n;
    logic [BLK_W-1:0]    blocks_r, blocks_n;
    logic [PERIOD_W-1:0] cnt_r, cnt_n;
    logic                tick_r, tick_n;
    logic                win_r, game_over_r;

    logic [PERIOD_W-1:0] period_s;
    logic                tick_due_s;
    logic [BLK_W-1:0]    keep_eff_s;
    logic [BLK_W-1:0]    next_cap_s;

    assign period_s   = period_of(level_r);
    assign tick_due_s = (cnt_r == period_s - PERIOD_W'(1));
    assign keep_eff_s = (place_keep < blocks_r) ? place_keep : blocks_r;
    assign next_cap_s = cap_of(level_r + LVL_W'(1));

    // Next-state, level/width update and tick counter.
    always_comb begin
        state_n  = state_r;
        level_n  = level_r;
        blocks_n = blocks_r;
        cnt_n    = cnt_r;
        tick_n   = 1'b0;
        case (state_r)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                cnt_n = PERIOD_W'(0);
                if (start) begin
                    state_n  = ST_PLAY;
                    level_n  = LVL_W'(1);
                    blocks_n = BLK_W'(START_BLOCKS);
                end else begin
                    state_n  = state_r;
                end
            end
            ST_PLAY: begin
                if (place_valid) begin
                    // A placement restarts the move count and swallows any tick due now.
                    cnt_n = PERIOD_W'(0);
                    if (keep_eff_s == BLK_W'(0)) begin
                        state_n = ST_LOSE;
                    end else if (level_r == LVL_W'(NUM_LEVELS)) begin
                        state_n  = ST_WIN;
                        blocks_n = keep_eff_s;
                    end else begin
                        level_n  = level_r + LVL_W'(1);
                        blocks_n = (keep_eff_s < next_cap_s) ? keep_eff_s : next_cap_s;
                    end
                end else if (tick_due_s) begin
                    cnt_n  = PERIOD_W'(0);
                    tick_n = 1'b1;
                end else begin
                    cnt_n = cnt_r + PERIOD_W'(1);
                end
            end
            default: begin
                state_n  = ST_IDLE;
                level_n  = LVL_W'(1);
                blocks_n = BLK_W'(START_BLOCKS);
                cnt_n    = PERIOD_W'(0);
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            level_r     <= LVL_W'(1);
            blocks_r    <= BLK_W'(START_BLOCKS);
            cnt_r       <= PERIOD_W'(0);
            tick_r      <= 1'b0;
            win_r       <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            level_r     <= level_n;
            blocks_r    <= blocks_n;
            cnt_r       <= cnt_n;
            tick_r      <= tick_n;
            win_r       <= (state_n == ST_WIN);
            game_over_r <= (state_n == ST_LOSE);
        end
    end

    assign level      = level_r;
    assign num_blocks = blocks_r;
    assign move_tick  = tick_r;
    assign game_state = state_r;
    assign win        = win_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_stacker_level_ctrl.sv
// Directed bench for stacker_level_ctrl with small periods and widths so
// every level, tick spacing and end-of-game path is reachable quickly.
module tb_stacker_level_ctrl;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       place_valid;
    logic [1:0] place_keep;
    logic [3:0] level;
    logic [1:0] num_blocks;
    logic       move_tick;
    logic [1:0] game_state;
    logic       win;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    stacker_level_ctrl #(
        .NUM_LEVELS(6), .LVL_W(4), .START_BLOCKS(3), .BLK_W(2),
        .SHRINK1(3), .SHRINK2(5), .PERIOD_W(24),
        .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .place_valid(place_valid), .place_keep(place_keep),
        .level(level), .num_blocks(num_blocks), .move_tick(move_tick),
        .game_state(game_state), .win(win), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic place(input logic [1:0] keep);
        place_valid = 1'b1;
        place_keep  = keep;
        step(1);
        place_valid = 1'b0;
        place_keep  = 2'd0;
    endtask

    // Cycles from now until move_tick is seen; 99 if it never comes.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!move_tick && n < 40);
        if (!move_tick) n = 99;
    endtask

    task automatic test_reset();
        int ticks;
        do_reset();
        checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", game_state); end
        checks++; if (level !== 4'd1) begin failures++; $display("FAIL reset_level got=%0d exp=1", level); end
        checks++; if (num_blocks !== 2'd3) begin failures++; $display("FAIL reset_blocks got=%0d exp=3", num_blocks); end
        checks++; if (win !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", win, game_over); end
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (move_tick) ticks++;
        end
        checks++; if (ticks !== 0) begin failures++; $display("FAIL idle_ticks got=%0d exp=0", ticks); end
        place(2'd1);
        checks++; if (level !== 4'd1 || num_blocks !== 2'd3 || game_state !== 2'd0) begin
            failures++; $display("FAIL idle_place_ignored got=L%0d B%0d S%0d exp=L1 B3 S0", level, num_blocks, game_state); end
    endtask

    task automatic test_tick_spacing();
        int exp_p [6] = '{10, 8, 6, 4, 4, 4};
        int n;
        do_reset();
        pulse_start();
        for (int lv = 1; lv <= 6; lv++) begin
            if (lv > 1) place(2'd3);
            checks++; if (level !== 4'(lv)) begin failures++; $display("FAIL spacing_level got=%0d exp=%0d", level, lv); end
            wait_tick(n);
            checks++; if (n !== exp_p[lv-1]) begin failures++; $display("FAIL first_tick L%0d got=%0d exp=%0d", lv, n, exp_p[lv-1]); end
            wait_tick(n);
            checks++; if (n !== exp_p[lv-1]) begin failures++; $display("FAIL tick_gap L%0d got=%0d exp=%0d", lv, n, exp_p[lv-1]); end
        end
    endtask

    task automatic test_full_and_win();
        int exp_b [6] = '{3, 3, 2, 2, 1, 1};
        int ticks;
        do_reset();
        pulse_start();
        for (int lv = 1; lv <= 6; lv++) begin
            checks++; if (level !== 4'(lv) || num_blocks !== 2'(exp_b[lv-1])) begin
                failures++; $display("FAIL full_row got=L%0d B%0d exp=L%0d B%0d", level, num_blocks, lv, exp_b[lv-1]); end
            place(2'd3);
        end
        checks++; if (game_state !== 2'd2 || win !== 1'b1 || game_over !== 1'b0) begin
            failures++; $display("FAIL win_state got=S%0d W%0b G%0b exp=S2 W1 G0", game_state, win, game_over); end
        checks++; if (level !== 4'd6 || num_blocks !== 2'd1) begin
            failures++; $display("FAIL win_hold got=L%0d B%0d exp=L6 B1", level, num_blocks); end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (move_tick) ticks++;
        end
        checks++; if (ticks !== 0) begin failures++; $display("FAIL win_ticks got=%0d exp=0", ticks); end
        start = 1'b1; place_valid = 1'b1; place_keep = 2'd0;
        step(1);
        start = 1'b0; place_valid = 1'b0;
        checks++; if (game_state !== 2'd1 || level !== 4'd1 || num_blocks !== 2'd3 || win !== 1'b0) begin
            failures++; $display("FAIL win_restart got=S%0d L%0d B%0d W%0b exp=S1 L1 B3 W0", game_state, level, num_blocks, win); end
    endtask

    task automatic test_partial();
        int n;
        do_reset();
        pulse_start();
        place(2'd1);
        checks++; if (level !== 4'd2 || num_blocks !== 2'd1) begin
            failures++; $display("FAIL partial_keep1 got=L%0d B%0d exp=L2 B1", level, num_blocks); end
        place(2'd3);
        checks++; if (level !== 4'd3 || num_blocks !== 2'd1) begin
            failures++; $display("FAIL partial_clamp got=L%0d B%0d exp=L3 B1", level, num_blocks); end
        step(5);
        checks++; if (move_tick !== 1'b0) begin failures++; $display("FAIL early_tick got=%0b exp=0", move_tick); end
        place(2'd1);
        checks++; if (move_tick !== 1'b0 || level !== 4'd4) begin
            failures++; $display("FAIL tick_suppress got=T%0b L%0d exp=T0 L4", move_tick, level); end
        wait_tick(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL tick_restart got=%0d exp=4", n); end
        pulse_start();
        checks++; if (level !== 4'd4 || game_state !== 2'd1) begin
            failures++; $display("FAIL play_start_ignored got=L%0d S%0d exp=L4 S1", level, game_state); end
    endtask

    task automatic test_lose();
        int ticks;
        do_reset();
        pulse_start();
        place(2'd3);
        place(2'd3);
        place(2'd0);
        checks++; if (game_state !== 2'd3 || game_over !== 1'b1 || win !== 1'b0) begin
            failures++; $display("FAIL lose_state got=S%0d G%0b W%0b exp=S3 G1 W0", game_state, game_over, win); end
        checks++; if (level !== 4'd3 || num_blocks !== 2'd2) begin
            failures++; $display("FAIL lose_hold got=L%0d B%0d exp=L3 B2", level, num_blocks); end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (move_tick) ticks++;
        end
        checks++; if (ticks !== 0) begin failures++; $display("FAIL lose_ticks got=%0d exp=0", ticks); end
        place(2'd2);
        checks++; if (level !== 4'd3 || game_state !== 2'd3) begin
            failures++; $display("FAIL lose_place_ignored got=L%0d S%0d exp=L3 S3", level, game_state); end
        pulse_start();
        checks++; if (game_state !== 2'd1 || level !== 4'd1 || num_blocks !== 2'd3 || game_over !== 1'b0) begin
            failures++; $display("FAIL lose_restart got=S%0d L%0d B%0d G%0b exp=S1 L1 B3 G0", game_state, level, num_blocks, game_over); end
    endtask

    task automatic test_reset_mid_game();
        do_reset();
        pulse_start();
        place(2'd3);
        place(2'd3);
        place(2'd3);
        checks++; if (level !== 4'd4) begin failures++; $display("FAIL mid_level got=%0d exp=4", level); end
        step(3);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        checks++; if (game_state !== 2'd0 || level !== 4'd1 || num_blocks !== 2'd3 || move_tick !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=S%0d L%0d B%0d T%0b exp=S0 L1 B3 T0", game_state, level, num_blocks, move_tick); end
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        place_valid = 1'b0;
        place_keep  = 2'd0;
        test_reset();
        test_tick_spacing();
        test_full_and_win();
        test_partial();
        test_lose();
        test_reset_mid_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
